// File: rtl/pio_key_poll_master_if.sv
// rtl/pio_key_poll_master_if.sv - Avalon-MM bus between the key poll master and the PIO slave.
interface pio_key_poll_master_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/pio_key_poll_master.sv
// rtl/pio_key_poll_master.sv - Avalon-MM master that masks PIO key irqs, then polls and debounces key levels.
module pio_key_poll_master #(
    parameter int KEY_WIDTH        = 2,
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    pio_key_poll_master_if.master    avm,
    output logic [KEY_WIDTH-1:0]     key_level,
    output logic [KEY_WIDTH-1:0]     key_press,
    output logic [KEY_WIDTH-1:0]     key_release,
    output logic                     sample_err,
    output logic                     busy
);

    localparam int POLL_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        DB_TH     = 4'(DEBOUNCE_SAMPLES);
    localparam logic [1:0]        ADDR_DATA = 2'd0;
    localparam logic [1:0]        ADDR_MASK = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT_WR,
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [POLL_W-1:0]    poll_cnt_q;
    logic [TMO_W-1:0]     tmo_cnt_q;

    logic                 write_q, write_d;
    logic                 read_q, read_d;
    logic [1:0]           addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 capture, timeout;

    logic                 samp_vld_q;
    logic [KEY_WIDTH-1:0] samp_q;

    logic [KEY_WIDTH-1:0] cand_q, cand_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] level_q, level_d;
    logic [KEY_WIDTH-1:0] press_q, press_d;
    logic [KEY_WIDTH-1:0] rel_q, rel_d;
    logic                 err_q;

    // Only the low key bits of the PIO data word carry information.
    logic                 unused_rd;
    assign unused_rd = ^avm.avm_readdata[31:KEY_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT_WR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT_WR: if (!avm.avm_waitrequest) state_d = ST_IDLE;
            ST_IDLE:    if (poll_cnt_q == '0)     state_d = ST_RD_REQ;
            ST_RD_REQ:  if (!avm.avm_waitrequest) state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (avm.avm_readdatavalid || (tmo_cnt_q == TMO_LAST)) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_INIT_WR;
        endcase
    end

    // Command outputs are registered from the next state so they move on the
    // edge that samples waitrequest low.
    always_comb begin
        write_d = (state_d == ST_INIT_WR);
        read_d  = (state_d == ST_RD_REQ);
        addr_d  = (state_d == ST_INIT_WR) ? ADDR_MASK : ADDR_DATA;
        busy_d  = (state_d != ST_IDLE);
        capture = (state_q == ST_RD_WAIT) && avm.avm_readdatavalid;
        timeout = (state_q == ST_RD_WAIT) && !avm.avm_readdatavalid && (tmo_cnt_q == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b1;
            read_q     <= 1'b0;
            addr_q     <= ADDR_MASK;
            busy_q     <= 1'b1;
            poll_cnt_q <= POLL_LOAD;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            samp_vld_q <= 1'b0;
            samp_q     <= '0;
        end else begin
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            // Counter sits at the reload value outside IDLE, so entry starts at POLL_CYCLES-1.
            if (state_q != ST_IDLE) begin
                poll_cnt_q <= POLL_LOAD;
            end else begin
                poll_cnt_q <= poll_cnt_q - 1'b1;
            end
            if (state_q == ST_RD_REQ) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_RD_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            samp_vld_q <= capture;
            if (capture) begin
                samp_q <= avm.avm_readdata[KEY_WIDTH-1:0];
            end
        end
    end

    // Whole-vector debounce: any bit change restarts the run for all bits.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        if (samp_vld_q) begin
            if (samp_q != cand_q) begin
                cand_d = samp_q;
                cnt_d  = 4'd1;
            end else if (cnt_q != 4'd15) begin
                cnt_d = cnt_q + 4'd1;
            end
            if ((cnt_d >= DB_TH) && (cand_d != level_q)) begin
                level_d = cand_d;
                press_d = cand_d & ~level_q;
                rel_d   = ~cand_d & level_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign avm.avm_address   = addr_q;
    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_writedata = 32'd0;

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign sample_err  = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pio_key_poll_master.sv
// tb/tb_pio_key_poll_master.sv - Bench for pio_key_poll_master: Avalon slave responder, run-length debounce model, directed checks.
module tb_pio_key_poll_master;

    localparam int P   = 4;
    localparam int LAT = 2;
    localparam int TMO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset       = 1'b1;
    logic       wr_stall    = 1'b1;
    logic       sched_valid = 1'b0;
    logic       inj_valid   = 1'b0;
    logic [1:0] slave_key   = 2'b00;
    bit         withhold    = 1'b0;
    bit         checking    = 1'b0;

    pio_key_poll_master_if bus_a ();
    pio_key_poll_master_if bus_b ();

    assign bus_a.avm_waitrequest   = wr_stall;
    assign bus_a.avm_readdatavalid = sched_valid | inj_valid;
    assign bus_a.avm_readdata      = inj_valid ? 32'd3 : {30'd0, slave_key};
    assign bus_b.avm_waitrequest   = wr_stall;
    assign bus_b.avm_readdatavalid = sched_valid | inj_valid;
    assign bus_b.avm_readdata      = inj_valid ? 32'd3 : {30'd0, slave_key};

    logic [1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
    logic       err_a, busy_a, err_b, busy_b;

    pio_key_poll_master #(.KEY_WIDTH(2), .POLL_CYCLES(P), .DEBOUNCE_SAMPLES(4), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .reset(reset), .avm(bus_a.master),
        .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
        .sample_err(err_a), .busy(busy_a)
    );

    pio_key_poll_master #(.KEY_WIDTH(2), .POLL_CYCLES(P), .DEBOUNCE_SAMPLES(1), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk(clk), .reset(reset), .avm(bus_b.master),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
        .sample_err(err_b), .busy(busy_b)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted samples form a history; a level change happens when the
    // trailing run of identical samples reaches the debounce depth.
    int         db[2] = '{4, 1};
    logic [1:0] hist[256];
    int         hlen = 0;
    logic [1:0] exp_lvl[2] = '{2'b00, 2'b00};
    logic [1:0] exp_prs[2] = '{2'b00, 2'b00};
    logic [1:0] exp_rel[2] = '{2'b00, 2'b00};
    logic [1:0] pend_lvl[2], pend_prs[2], pend_rel[2];
    int         pend_at[2] = '{-1, -1};
    logic       exp_err = 1'b0;
    int         cyc = 0;
    int         resp_at = -1;
    int         err_at = -1;
    int         resp_cnt = 0;
    bit         acc_seen = 1'b0;

    function automatic int trailing_run();
        int r = 0;
        for (int i = hlen - 1; i >= 0; i--) begin
            if (hist[i] == hist[hlen-1]) r++;
            else break;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [1:0] s;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (cyc == pend_at[k]) begin
                exp_lvl[k] = pend_lvl[k];
                exp_prs[k] = pend_prs[k];
                exp_rel[k] = pend_rel[k];
            end else begin
                exp_prs[k] = 2'b00;
                exp_rel[k] = 2'b00;
            end
        end
        if (cyc == err_at) exp_err = 1'b1;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                exp_lvl[k] = 2'b00;
                exp_prs[k] = 2'b00;
                exp_rel[k] = 2'b00;
                pend_at[k] = -1;
            end
            exp_err = 1'b0;
            hlen    = 0;
            resp_at = -1;
            err_at  = -1;
        end else begin
            if (bus_a.avm_read && !bus_a.avm_waitrequest) begin
                acc_seen = 1'b1;
                if (withhold) err_at = cyc + TMO;
                else          resp_at = cyc + LAT;
            end
            if (bus_a.avm_readdatavalid && !inj_valid) begin
                s = bus_a.avm_readdata[1:0];
                if (hlen < 256) begin
                    hist[hlen] = s;
                    hlen++;
                end
                resp_cnt++;
                for (int k = 0; k < 2; k++) begin
                    if (trailing_run() >= db[k] && s != exp_lvl[k]) begin
                        pend_lvl[k] = s;
                        pend_prs[k] = s & ~exp_lvl[k];
                        pend_rel[k] = ~s & exp_lvl[k];
                        pend_at[k]  = cyc + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        sched_valid = (cyc + 1 == resp_at);
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("level_a", lvl_a, exp_lvl[0]);
            chk("press_a", prs_a, exp_prs[0]);
            chk("release_a", rel_a, exp_rel[0]);
            chk("err_a", err_a, exp_err);
            chk("level_b", lvl_b, exp_lvl[1]);
            chk("press_b", prs_b, exp_prs[1]);
            chk("release_b", rel_b, exp_rel[1]);
            chk("err_b", err_b, exp_err);
            chk("rd_wr_excl", bus_a.avm_read & bus_a.avm_write, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_samples(input int n, input string name);
        int target = resp_cnt + n;
        int budget = 200;
        while (resp_cnt < target && budget > 0) begin
            step();
            budget--;
        end
        if (resp_cnt < target) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0d samples expected %0d (timed out)", name, resp_cnt, target);
        end
    endtask

    task automatic wait_accept(input string name);
        int budget = 200;
        acc_seen = 1'b0;
        while (!acc_seen && budget > 0) begin
            step();
            budget--;
        end
        if (!acc_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no read acceptance expected one (timed out)", name);
        end
    endtask

    initial begin
        // Init write: stall 3 cycles, write held 4, then 4 idle cycles before the read.
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        checking = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("init_write", bus_a.avm_write, 1'b1);
            chk("init_addr", bus_a.avm_address, 2'd2);
            chk("init_wdata", bus_a.avm_writedata, 32'd0);
            chk("init_read", bus_a.avm_read, 1'b0);
            chk("init_busy", busy_a, 1'b1);
            if (i == 4) wr_stall = 1'b0;
            step();
        end
        chk("init_done_write", bus_a.avm_write, 1'b0);
        chk("idle_busy", busy_a, 1'b0);
        for (int i = 5; i <= 8; i++) begin
            chk("idle_no_read", bus_a.avm_read, 1'b0);
            step();
        end
        chk("poll_read", bus_a.avm_read, 1'b1);
        chk("poll_addr", bus_a.avm_address, 2'd0);
        chk("poll_busy", busy_a, 1'b1);

        // Steady press of 01.
        slave_key = 2'b01;
        wait_samples(4, "steady_wait");
        chk("steady_lvl_before", lvl_a, 2'b00);
        step();
        chk("steady_lvl", lvl_a, 2'b01);
        chk("steady_press", prs_a, 2'b01);
        step();
        chk("steady_press_off", prs_a, 2'b00);

        // Glitch rejection: 00 01 00 00 00 00.
        slave_key = 2'b00; wait_samples(1, "glitch1");
        slave_key = 2'b01; wait_samples(1, "glitch2");
        slave_key = 2'b00;
        for (int i = 0; i < 3; i++) wait_samples(1, "glitch3");
        step();
        chk("glitch_hold", lvl_a, 2'b01);
        wait_samples(1, "glitch6");
        step();
        chk("glitch_lvl", lvl_a, 2'b00);
        chk("glitch_release", rel_a, 2'b01);
        chk("glitch_no_press", prs_a, 2'b00);

        // Timeout: response withheld.
        withhold = 1'b1;
        wait_accept("tmo_accept");
        repeat (14) step();
        chk("tmo_err_early", err_a, 1'b0);
        withhold = 1'b0;
        step();
        chk("tmo_err", err_a, 1'b1);
        wait_samples(1, "tmo_next_poll");
        step();
        chk("tmo_lvl", lvl_a, 2'b00);
        chk("tmo_err_sticky", err_a, 1'b1);

        // Reset mid-read with a stale valid carrying 11.
        withhold = 1'b1;
        wait_accept("rst_accept");
        reset    = 1'b1;
        wr_stall = 1'b1;
        withhold = 1'b0;
        step();
        reset     = 1'b0;
        inj_valid = 1'b1;
        chk("rst_write", bus_a.avm_write, 1'b1);
        chk("rst_addr", bus_a.avm_address, 2'd2);
        chk("rst_read", bus_a.avm_read, 1'b0);
        chk("rst_err", err_a, 1'b0);
        step();
        inj_valid = 1'b0;
        wr_stall  = 1'b0;
        chk("rst_write_held", bus_a.avm_write, 1'b1);
        step();
        chk("rst_write_done", bus_a.avm_write, 1'b0);
        repeat (3) step();
        chk("stale_lvl_a", lvl_a, 2'b00);
        chk("stale_lvl_b", lvl_b, 2'b00);

        // Dual-bit transition on the single-sample instance.
        slave_key = 2'b01;
        wait_samples(2, "dual_01");
        slave_key = 2'b10;
        wait_samples(1, "dual_10");
        chk("dual_lvl_before", lvl_b, 2'b01);
        step();
        chk("dual_lvl", lvl_b, 2'b10);
        chk("dual_press", prs_b, 2'b10);
        chk("dual_release", rel_b, 2'b01);
        repeat (3) step();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
